// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned LU_BUBBLES_MAX = 3;
  localparam int unsigned BUB_W          = $clog2(LU_BUBBLES_MAX + 1);

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   clr : synchronous clear (highest priority)
//   inc : add one unless already all-ones
//   cnt : current count
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: load-use bubbles,
// branch flushes and data-memory freeze. Outputs are combinational so a
// hazard takes effect in the cycle it is seen.
//   clk, rst            : clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt : source registers of the ID instruction
//   id_ex_memread/id_ex_rt : load in EX and its destination
//   branch_taken        : branch in EX resolved taken
//   mem_busy            : data memory not ready
//   pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, stall
// Optional macro HAZ_PERF_CNT_EN adds parameter CNT_W and saturating
// counters lu_stall_cnt, mem_wait_cnt, flush_cnt.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_en,
  output logic       stall
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] lu_stall_cnt
  , output logic [CNT_W-1:0] mem_wait_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [BUB_W-1:0] LU_INIT = BUB_W'(LU_BUBBLES - 1);

  state_t           state, state_nxt;
  state_t           ret_state, ret_nxt;
  state_t           eval_st;
  logic [BUB_W-1:0] bub_cnt, bub_nxt;
  logic             lu;
  logic             lu_bub_c, frz_c, flush_c;

  assign lu = id_ex_memread && (id_ex_rt != REG_ZERO) &&
              ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  // Leaving MEM_WAIT is evaluated with the rules of the interrupted state.
  assign eval_st = (state == MEM_WAIT) ? ret_state : state;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      bub_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      bub_cnt   <= bub_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b1;
    state_nxt   = state;
    ret_nxt     = ret_state;
    bub_nxt     = bub_cnt;
    lu_bub_c    = 1'b0;
    frz_c       = 1'b0;
    flush_c     = 1'b0;

    if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_en     = 1'b0;
      frz_c       = 1'b1;
      if (state != MEM_WAIT) begin
        ret_nxt = state;
      end
      state_nxt = MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_c     = 1'b1;
      bub_nxt     = '0;
      state_nxt   = RUN;
    end else if (eval_st == LU_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      lu_bub_c    = 1'b1;
      bub_nxt     = bub_cnt - BUB_W'(1);
      state_nxt   = (bub_nxt == '0) ? RUN : LU_STALL;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      lu_bub_c    = 1'b1;
      bub_nxt     = LU_INIT;
      state_nxt   = (LU_INIT == '0) ? RUN : LU_STALL;
    end else begin
      state_nxt = RUN;
    end

    // Reset pushes bubbles through the back end while holding the front.
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_en     = 1'b1;
      lu_bub_c    = 1'b0;
      frz_c       = 1'b0;
      flush_c     = 1'b0;
    end

    stall = !pc_write && !rst;
  end

`ifdef HAZ_PERF_CNT_EN
  sat_cnt #(.W(CNT_W)) u_lu_cnt (
    .clk (clk), .clr (rst), .inc (lu_bub_c), .cnt (lu_stall_cnt)
  );
  sat_cnt #(.W(CNT_W)) u_mem_cnt (
    .clk (clk), .clr (rst), .inc (frz_c), .cnt (mem_wait_cnt)
  );
  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .clr (rst), .inc (flush_c), .cnt (flush_cnt)
  );
`else
  logic unused_stat;
  assign unused_stat = lu_bub_c ^ frz_c ^ flush_c;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (1 and 3 load-use bubbles)
// share stimulus; outputs packed as {pc_write,if_id_write,if_id_flush,
// id_ex_flush,pipe_en,stall}.
module tb_hazard_ctrl;

  localparam logic [5:0] NORM = 6'b110010;
  localparam logic [5:0] BR   = 6'b111110;
  localparam logic [5:0] LUB  = 6'b000111;
  localparam logic [5:0] FRZ  = 6'b000001;
  localparam logic [5:0] RSTV = 6'b001110;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rt, id_ex_memread, branch_taken, mem_busy;

  logic pcw1, ifw1, iff1, idf1, pe1, st1;
  logic pcw3, ifw3, iff3, idf3, pe3, st3;
  logic [5:0] o1, o3;

  int errors = 0;
  int checks = 0;

  assign o1 = {pcw1, ifw1, iff1, idf1, pe1, st1};
  assign o3 = {pcw3, ifw3, iff3, idf3, pe3, st3};

`ifdef HAZ_PERF_CNT_EN
  logic [1:0]  lcnt1, mcnt1, fcnt1;
  logic [15:0] lcnt3, mcnt3, fcnt3;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .LU_BUBBLES (1)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W (2)
`endif
  ) dut1 (
    .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt),
    .id_uses_rt (id_uses_rt), .id_ex_memread (id_ex_memread),
    .id_ex_rt (id_ex_rt), .branch_taken (branch_taken), .mem_busy (mem_busy),
    .pc_write (pcw1), .if_id_write (ifw1), .if_id_flush (iff1),
    .id_ex_flush (idf1), .pipe_en (pe1), .stall (st1)
`ifdef HAZ_PERF_CNT_EN
    , .lu_stall_cnt (lcnt1), .mem_wait_cnt (mcnt1), .flush_cnt (fcnt1)
`endif
  );

  hazard_ctrl #(
    .LU_BUBBLES (3)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W (16)
`endif
  ) dut3 (
    .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt),
    .id_uses_rt (id_uses_rt), .id_ex_memread (id_ex_memread),
    .id_ex_rt (id_ex_rt), .branch_taken (branch_taken), .mem_busy (mem_busy),
    .pc_write (pcw3), .if_id_write (ifw3), .if_id_flush (iff3),
    .id_ex_flush (idf3), .pipe_en (pe3), .stall (st3)
`ifdef HAZ_PERF_CNT_EN
    , .lu_stall_cnt (lcnt3), .mem_wait_cnt (mcnt3), .flush_cnt (fcnt3)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic setin(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br, input logic busy);
    rst = r; id_ex_memread = mr; id_ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; branch_taken = br; mem_busy = busy;
  endtask

  // Inputs change at negedge; combinational outputs are sampled 2 units later.
  task automatic step(input string tag, input logic [5:0] e1,
                      input logic [5:0] e3);
    #2;
    chk({tag, "/lu1"}, 16'(o1), 16'(e1));
    chk({tag, "/lu3"}, 16'(o3), 16'(e3));
    @(negedge clk);
  endtask

  initial begin
    setin(1, 0, 0, 0, 0, 0, 0, 0); step("reset0", RSTV, RSTV);
    setin(1, 0, 0, 0, 0, 0, 0, 0); step("reset1", RSTV, RSTV);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("idle", NORM, NORM);

    // Load-use on rs: one bubble vs three bubbles
    setin(0, 1, 8, 8, 0, 0, 0, 0); step("lu_rs", LUB, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("lu_b2", NORM, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("lu_b3", NORM, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("lu_done", NORM, NORM);

    // Zero register and unused rt never stall
    setin(0, 1, 0, 0, 0, 0, 0, 0); step("rzero", NORM, NORM);
    setin(0, 1, 9, 1, 9, 0, 0, 0); step("rt_unused", NORM, NORM);

    // Load-use on rt, then memory busy during the second bubble
    setin(0, 1, 9, 1, 9, 1, 0, 0); step("lu_rt", LUB, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 1); step("busy_a", FRZ, FRZ);
    setin(0, 0, 0, 0, 0, 0, 0, 1); step("busy_b", FRZ, FRZ);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("resume_b2", NORM, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("resume_b3", NORM, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("after_lu", NORM, NORM);

    // Branch held while memory busy: freeze first, flush once free
    setin(0, 0, 0, 0, 0, 0, 1, 1); step("br_busy_a", FRZ, FRZ);
    setin(0, 0, 0, 0, 0, 0, 1, 1); step("br_busy_b", FRZ, FRZ);
    setin(0, 0, 0, 0, 0, 0, 1, 0); step("br_free", BR, BR);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("br_after", NORM, NORM);

    // Branch aborts a load-use stall
    setin(0, 1, 8, 8, 0, 0, 0, 0); step("lu_pre_br", LUB, LUB);
    setin(0, 0, 0, 0, 0, 0, 1, 0); step("br_abort", BR, BR);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("abort_after", NORM, NORM);

    // Reset mid-stall
    setin(0, 1, 8, 8, 0, 0, 0, 0); step("lu_pre_rst", LUB, LUB);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("lu_b2_rst", NORM, LUB);
    setin(1, 0, 0, 0, 0, 0, 0, 0); step("rst_stall", RSTV, RSTV);
    setin(0, 0, 0, 0, 0, 0, 0, 0); step("post_rst_s", NORM, NORM);

    // Reset mid-wait
    setin(0, 0, 0, 0, 0, 0, 0, 1); step("wait_pre_rst", FRZ, FRZ);
    setin(1, 0, 0, 0, 0, 0, 0, 1); step("rst_wait", RSTV, RSTV);
    setin(0, 0, 0, 0, 0, 0, 0, 0); #2;
`ifdef HAZ_PERF_CNT_EN
    chk("cnt_clr_lu", 16'(lcnt1), 16'd0);
    chk("cnt_clr_mem", 16'(mcnt1), 16'd0);
    chk("cnt_clr_fl", 16'(fcnt1), 16'd0);
`endif
    step("post_rst_w", NORM, NORM);

    // Branch has priority over load-use in RUN
    setin(0, 1, 8, 8, 0, 0, 1, 0); step("br_over_lu", BR, BR);
    setin(0, 0, 0, 0, 0, 0, 0, 0); #2;
`ifdef HAZ_PERF_CNT_EN
    chk("cnt_flush1", 16'(fcnt1), 16'd1);
    chk("cnt_mem0", 16'(mcnt1), 16'd0);
`endif
    step("br_over_after", NORM, NORM);

    // Five back-to-back load-use cycles
    for (int i = 0; i < 5; i++) begin
      setin(0, 1, 8, 8, 0, 0, 0, 0); step("lu_run", LUB, LUB);
    end
    setin(1, 0, 0, 0, 0, 0, 0, 0); #2;
`ifdef HAZ_PERF_CNT_EN
    chk("cnt_lu_sat", 16'(lcnt1), 16'd3);
`endif
    step("rst_end", RSTV, RSTV);
    setin(0, 0, 0, 0, 0, 0, 0, 0); #2;
`ifdef HAZ_PERF_CNT_EN
    chk("cnt_lu_clr", 16'(lcnt1), 16'd0);
`endif
    step("end_idle", NORM, NORM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
